// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions: fetch FSM states, default datapath widths and
// the bubble encoding used by the fetch stage and the downstream pipeline registers.
package if_fetch_stage_pkg;

  localparam int DEF_PC_W  = 9;
  localparam int DEF_INS_W = 32;

  // addi x0, x0, 0
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    READY,
    FLUSH
  } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues req/ack fetches to instruction memory
// and presents PC / PCPlus4 / inst_code to IF/ID, inserting bubbles on busy or redirect.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter int               PC_W     = DEF_PC_W,
  parameter int               INS_W    = DEF_INS_W,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [INS_W-1:0] NOP_INST = INS_W'(DEF_NOP_INST)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_detected,
  input  logic             br_taken,
  input  logic [PC_W-1:0]  br_target,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_rdata,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  PCPlus4,
  output logic [INS_W-1:0] inst_code,
  output logic             inst_valid
);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  flush_addr_q;
  logic [INS_W-1:0] inst_q;

  logic [PC_W-1:0]  pc_plus4;
  logic [PC_W-1:0]  br_pc;
  logic             fetch_ack;
  logic             consume;
  logic             unused_br_lsbs;

  // The adder wraps naturally at 2^PC_W.
  assign pc_plus4       = pc_q + PC_W'(4);
  assign br_pc          = {br_target[PC_W-1:2], 2'b00};
  assign unused_br_lsbs = ^br_target[1:0];

  // Gating with reset keeps the bubble on the outputs while reset is held.
  assign fetch_ack  = (state_q == FETCH) && imem_ack && !reset;
  assign inst_valid = !br_taken && ((state_q == READY) || fetch_ack);
  assign consume    = inst_valid && !hazard_detected;

  // Memory-side outputs depend only on registered state, never on hazard_detected.
  assign imem_req  = (state_q != READY);
  assign imem_addr = (state_q == FLUSH) ? flush_addr_q : pc_q;
  assign PC        = pc_q;
  assign PCPlus4   = pc_plus4;

  always_comb begin
    inst_code = NOP_INST;
    if (!br_taken) begin
      if (state_q == READY) inst_code = inst_q;
      else if (fetch_ack)   inst_code = imem_rdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every branch below
  // sees the pre-edge values of pc_q/state_q, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      flush_addr_q <= RESET_PC;
      inst_q       <= NOP_INST;
    end else if (br_taken) begin
      pc_q <= br_pc;
      case (state_q)
        FETCH: if (!imem_ack) begin
          flush_addr_q <= pc_q;
          state_q      <= FLUSH;
        end
        READY:   state_q <= FETCH;
        FLUSH:   if (imem_ack) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end else if (consume) begin
      pc_q    <= pc_plus4;
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH: if (imem_ack) begin
          inst_q  <= imem_rdata;
          state_q <= READY;
        end
        FLUSH:   if (imem_ack) state_q <= FETCH;
        default: state_q <= state_q;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed phases push expected fetches, a
// monitor compares each presented instruction; a variable-latency memory model answers requests.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        hazard_detected;
  logic        br_taken;
  logic [8:0]  br_target;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [8:0]  PC;
  logic [8:0]  PCPlus4;
  logic [31:0] inst_code;
  logic        inst_valid;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic [8:0]  mem_addr = '0;
  logic [8:0]  exp_q[$];

  if_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .hazard_detected (hazard_detected),
    .br_taken        (br_taken),
    .br_target       (br_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .PC              (PC),
    .PCPlus4         (PCPlus4),
    .inst_code       (inst_code),
    .inst_valid      (inst_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] tag(input logic [8:0] a);
    return 32'hC0DE_0000 | {23'd0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic hz, input logic br, input logic [8:0] tgt);
    @(posedge clk);
    #1;
    hazard_detected = hz;
    br_taken        = br;
    br_target       = tgt;
  endtask

  task automatic do_reset(input int lat);
    @(posedge clk);
    #1;
    reset           = 1'b1;
    hazard_detected = 1'b0;
    br_taken        = 1'b0;
    br_target       = '0;
    mem_lat         = lat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag_name);
    check({tag_name, "_imem_req"},   32'(imem_req),   32'd1);
    check({tag_name, "_imem_addr"},  32'(imem_addr),  32'h000);
    check({tag_name, "_pc"},         32'(PC),         32'h000);
    check({tag_name, "_pcplus4"},    32'(PCPlus4),    32'h004);
    check({tag_name, "_inst_code"},  inst_code,       NOP);
    check({tag_name, "_inst_valid"}, 32'(inst_valid), 32'd0);
  endtask

  task automatic check_bubble(input string name);
    check({name, "_inst_valid"}, 32'(inst_valid), 32'd0);
    check({name, "_inst_code"},  inst_code,       NOP);
  endtask

  // Memory model: acks on the mem_lat-th cycle of each request, data tagged with the address.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || !imem_req) begin
        mem_cnt  = 0;
        imem_ack = 1'b0;
      end else begin
        if (imem_ack || mem_cnt == 0) begin
          mem_cnt  = 1;
          mem_addr = imem_addr;
        end else begin
          mem_cnt++;
          check("imem_addr_stable", 32'(imem_addr), 32'(mem_addr));
        end
        imem_ack   = (mem_cnt >= mem_lat);
        imem_rdata = tag(imem_addr);
      end
    end
  end

  // Monitor: every presented instruction is compared with the scoreboard head;
  // it is popped only when IF/ID actually takes it (no stall).
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && inst_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got PC %h, expected no instruction (t=%0t)", PC, $time);
        end else begin
          logic [8:0] e;
          logic [8:0] e4;
          e  = exp_q[0];
          e4 = e + 9'd4;
          check("mon_pc",        32'(PC),      32'(e));
          check("mon_pcplus4",   32'(PCPlus4), 32'(e4));
          check("mon_inst_code", inst_code,    tag(e));
          if (!hazard_detected) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset           = 1'b0;
    hazard_detected = 1'b0;
    br_taken        = 1'b0;
    br_target       = '0;
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("por");

    // Zero-wait memory: one instruction per cycle from RESET_PC.
    do_reset(1);
    for (int i = 0; i < 8; i++) exp_q.push_back(9'(4 * i));
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);

    // Latency 3: two bubbles before each instruction.
    do_reset(3);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h004);
    exp_q.push_back(9'h008);
    for (int c = 1; c <= 9; c++) begin
      step(1'b0, 1'b0, '0);
      @(negedge clk);
      if (c % 3 != 0) begin
        check_bubble("lat3_bubble");
        check("lat3_req", 32'(imem_req), 32'd1);
      end
    end

    // Stall for 4 cycles on the instruction at 0x10.
    do_reset(1);
    for (int i = 0; i < 6; i++) exp_q.push_back(9'(4 * i));
    for (int c = 1; c <= 4; c++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    for (int c = 6; c <= 8; c++) begin
      step(1'b1, 1'b0, '0);
      @(negedge clk);
      check("stall_req",        32'(imem_req),   32'd0);
      check("stall_pc",         32'(PC),         32'h010);
      check("stall_inst_code",  inst_code,       tag(9'h010));
      check("stall_inst_valid", 32'(inst_valid), 32'd1);
    end
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("release_req", 32'(imem_req), 32'd0);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("refetch_req",  32'(imem_req),  32'd1);
    check("refetch_addr", 32'(imem_addr), 32'h014);

    // Latency 3: redirect to 0x43 while the fetch of 0x08 is outstanding.
    do_reset(3);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h004);
    exp_q.push_back(9'h040);
    for (int c = 1; c <= 6; c++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 9'h043);
    @(negedge clk);
    check_bubble("redir_cycle");
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("flush_addr", 32'(imem_addr), 32'h008);
    check("flush_req",  32'(imem_req),  32'd1);
    check("flush_pc",   32'(PC),        32'h040);
    check_bubble("flush_wait");
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("flush_ack_seen", 32'(imem_ack), 32'd1);
    check_bubble("flush_discard");
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("post_flush_addr", 32'(imem_addr), 32'h040);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Zero-wait: redirect in the same cycle as an ack under stall.
    do_reset(1);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h004);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h104);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 9'h100);
    @(negedge clk);
    check_bubble("br_ack_stall");
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("br_ack_next_addr", 32'(imem_addr), 32'h100);
    step(1'b0, 1'b0, '0);

    // PC wrap at the top of the address space.
    do_reset(1);
    exp_q.push_back(9'h1F8);
    exp_q.push_back(9'h1FC);
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h004);
    step(1'b0, 1'b1, 9'h1F8);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("wrap_pc",      32'(PC),      32'h1FC);
    check("wrap_pcplus4", 32'(PCPlus4), 32'h000);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);

    // Latency 3: asynchronous reset asserted while in FLUSH.
    do_reset(3);
    step(1'b0, 1'b1, 9'h080);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    check("pre_reset_flush_addr", 32'(imem_addr), 32'h000);
    check("pre_reset_flush_pc",   32'(PC),        32'h080);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    mem_lat = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(9'h000);
    exp_q.push_back(9'h004);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
